// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared constants, scheduler state encoding and coefficient lift helper
package kyber_pkg;

    localparam int KYBER_Q    = 3329;
    localparam int COEF_W     = 12;
    localparam int N_COEF     = 256;
    localparam int K          = 2;
    localparam int LANES      = 7;
    localparam int WORD_COEFS = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int ACC_COEFS  = 14;
    localparam int WORD_W     = COEF_W * WORD_COEFS;
    localparam int ACC_W      = COEF_W * ACC_COEFS;
    localparam int LANE_W     = COEF_W * LANES;
    localparam int ENTRY_W    = 2 + 5 + WORD_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_COLLECT = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_NEXT    = 3'd4,
        ST_FLUSH   = 3'd5,
        ST_FIN     = 3'd6
    } sched_state_t;

    // 12-bit wraparound of sext(x)+Q lands exactly on x+Q for x in -3..-1
    function automatic logic [COEF_W-1:0] lift_coef(input logic [2:0] x);
        logic [COEF_W-1:0] sx;
        sx = {{(COEF_W-3){x[2]}}, x};
        return x[2] ? sx + COEF_W'(KYBER_Q) : sx;
    endfunction

endpackage

// File: rtl/cbd_word_fifo.sv
// rtl/cbd_word_fifo.sv - show-ahead word FIFO; push and pop on a full FIFO both succeed
module cbd_word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 103
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_pop;
    logic         w_do_push;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/cbd_poly_sched.sv
// rtl/cbd_poly_sched.sv - CBD batch sequencer: lift, pack 8 coefs/word, stream through FIFO
// Optional CBD_SCHED_CNTCHK_EN: per-poly coefficient count check instead of zero-padding residue.
module cbd_poly_sched
    import kyber_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_req,
    input  logic [7:0]        i_nonce_base,
    input  logic [2:0]        i_npoly,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_cbd_start,
    output logic [7:0]        o_cbd_n,
    input  logic [20:0]       i_cbd_coef,
    input  logic [2:0]        i_cbd_num,
    input  logic              i_cbd_done,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [WORD_W-1:0] o_data,
    output logic [1:0]        o_poly_idx,
    output logic [4:0]        o_word_idx
);

    sched_state_t        r_state;
    sched_state_t        w_next_state;
    logic [7:0]          r_base;
    logic [2:0]          r_npoly;
    logic [1:0]          r_poly_idx;
    logic [4:0]          r_word_idx;
    logic [ACC_W-1:0]    r_acc;
    logic [3:0]          r_acc_cnt;
    logic                r_err;

    logic [LANE_W-1:0]   w_lanes;
    logic [ACC_W-1:0]    w_comb;
    logic [3:0]          w_comb_cnt;
    logic [ACC_W-1:0]    w_acc_after;
    logic [3:0]          w_cnt_after;
    logic                w_collect;
    logic                w_take;
    logic                w_drain_push;
    logic                w_push;
    logic [WORD_W-1:0]   w_push_word;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_drop;
    logic                w_cnt_bad;
    logic [ENTRY_W-1:0]  w_rdata;

    // i_cbd_num is 3 bits, so it can never exceed LANES; no clamp needed
    always_comb begin
        w_lanes = '0;
        for (int l = 0; l < LANES; l++) begin
            if (3'(l) < i_cbd_num) w_lanes[l*COEF_W +: COEF_W] = lift_coef(i_cbd_coef[3*l +: 3]);
        end
    end

    assign w_collect    = (r_state == ST_COLLECT);
    assign w_comb       = r_acc | (ACC_W'(w_lanes) << (COEF_W * int'(r_acc_cnt)));
    assign w_comb_cnt   = r_acc_cnt + {1'b0, i_cbd_num};
    assign w_take       = w_collect && (w_comb_cnt >= 4'(WORD_COEFS));
    assign w_acc_after  = w_take ? (w_comb >> WORD_W) : w_comb;
    assign w_cnt_after  = w_take ? (w_comb_cnt - 4'(WORD_COEFS)) : w_comb_cnt;
    assign w_drain_push = (r_state == ST_DRAIN) && (r_acc_cnt != 4'd0);
    assign w_push       = w_take || w_drain_push;
    // accumulator bits above the count are always zero, so a drained residue is already padded
    assign w_push_word  = w_take ? w_comb[WORD_W-1:0] : r_acc[WORD_W-1:0];
    assign w_pop        = !w_empty && i_ready;
    assign w_drop       = w_push && w_full && !w_pop;

`ifdef CBD_SCHED_CNTCHK_EN
    logic [9:0] r_total;
    logic [9:0] w_total_next;

    assign w_total_next = r_total + 10'(i_cbd_num);
    assign w_cnt_bad    = w_collect && i_cbd_done &&
                          ((w_total_next != 10'(N_COEF)) || (w_cnt_after != 4'd0));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)                 r_total <= '0;
        else if (r_state == ST_START) r_total <= '0;
        else if (w_collect)          r_total <= w_total_next;
    end
`else
    assign w_cnt_bad = 1'b0;
`endif

    cbd_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (w_push),
        .i_wdata ({r_poly_idx, r_word_idx, w_push_word}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (i_req) w_next_state = ST_START;
            ST_START:   w_next_state = ST_COLLECT;
            ST_COLLECT: if (i_cbd_done) w_next_state = ST_DRAIN;
            ST_DRAIN:   if (r_acc_cnt == 4'd0) w_next_state = ST_NEXT;
            ST_NEXT:    w_next_state = (({1'b0, r_poly_idx} + 3'd1) < r_npoly) ? ST_START : ST_FLUSH;
            ST_FLUSH:   if (w_empty) w_next_state = ST_FIN;
            ST_FIN:     w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (r_state != ST_IDLE);
        o_cbd_start = (r_state == ST_START);
        o_done      = (r_state == ST_FIN);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_base     <= '0;
            r_npoly    <= '0;
            r_poly_idx <= '0;
            r_word_idx <= '0;
            r_acc      <= '0;
            r_acc_cnt  <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && i_req) begin
                r_base     <= i_nonce_base;
                r_npoly    <= (i_npoly == 3'd0) ? 3'd1 : ((i_npoly > 3'd4) ? 3'd4 : i_npoly);
                r_poly_idx <= '0;
                r_word_idx <= '0;
                r_acc      <= '0;
                r_acc_cnt  <= '0;
                r_err      <= 1'b0;
            end
            if (w_collect) begin
                if (w_cnt_bad) begin
                    r_acc     <= '0;
                    r_acc_cnt <= '0;
                end else begin
                    r_acc     <= w_acc_after;
                    r_acc_cnt <= w_cnt_after;
                end
            end
            if (w_drain_push) begin
                r_acc     <= '0;
                r_acc_cnt <= '0;
            end
            if (w_push) r_word_idx <= r_word_idx + 5'd1;
            if (r_state == ST_NEXT) begin
                r_poly_idx <= r_poly_idx + 2'd1;
                r_word_idx <= '0;
            end
            if (w_drop || w_cnt_bad) r_err <= 1'b1;
        end
    end

    assign o_err      = r_err;
    assign o_cbd_n    = r_base + {6'd0, r_poly_idx};
    assign o_valid    = !w_empty;
    assign o_poly_idx = w_rdata[ENTRY_W-1 -: 2];
    assign o_word_idx = w_rdata[WORD_W +: 5];
    assign o_data     = w_rdata[WORD_W-1:0];

endmodule

// File: tb/tb_cbd_poly_sched.sv
// tb/tb_cbd_poly_sched.sv - directed bench with behavioral CBD source and output word scoreboard
module tb_cbd_poly_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [7:0]  nonce = 8'h00;
    logic [2:0]  npoly = 3'd0;
    logic        o_busy, o_done, o_err, o_cbd_start, o_valid;
    logic [7:0]  o_cbd_n;
    logic [20:0] cbd_coef = '0;
    logic [2:0]  cbd_num = '0;
    logic        cbd_done = 1'b0;
    logic        i_ready = 1'b1;
    logic [95:0] o_data;
    logic [1:0]  o_poly_idx;
    logic [4:0]  o_word_idx;

    typedef struct {
        logic [95:0] data;
        logic [1:0]  pidx;
        logic [4:0]  widx;
    } exp_t;

    exp_t        exp_q[$];
    int          sched[$];
    int          checks = 0;
    int          errors = 0;
    int          n_start = 0;
    int          n_done = 0;
    int          n_words = 0;
    bit          sb_en = 1'b1;
    int          exp_gen = 0;
    int          exp_limit = 0;
    logic [95:0] wbuf = '0;
    int          wcnt = 0;
    int          widx_m = 0;

    cbd_poly_sched dut (
        .i_clk        (clk),
        .i_rstn       (rst_n),
        .i_req        (i_req),
        .i_nonce_base (nonce),
        .i_npoly      (npoly),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_cbd_start  (o_cbd_start),
        .o_cbd_n      (o_cbd_n),
        .i_cbd_coef   (cbd_coef),
        .i_cbd_num    (cbd_num),
        .i_cbd_done   (cbd_done),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_poly_idx   (o_poly_idx),
        .o_word_idx   (o_word_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_cbd_start) n_start++;
        if (o_done) n_done++;
        if (sb_en && o_valid && i_ready) begin
            n_words++;
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("word_data", o_data, e.data);
                chk("word_pidx", o_poly_idx, e.pidx);
                chk("word_widx", o_word_idx, e.widx);
            end
        end
    end

    task automatic sched_fill(input int n, input int lanes);
        for (int i = 0; i < n; i++) sched.push_back(lanes);
    endtask

    task automatic build_sched(input int kind);
        sched.delete();
        case (kind)
            0: begin sched_fill(25, 7); sched_fill(1, 6); sched_fill(10, 7); sched_fill(1, 5); end
            1: sched_fill(64, 4);
            default: begin sched_fill(36, 7); sched_fill(1, 3); end
        endcase
    endtask

    task automatic push_exp(input int p);
        exp_t e;
        if (exp_gen < exp_limit) begin
            e.data = wbuf;
            e.pidx = 2'(p);
            e.widx = 5'(widx_m);
            exp_q.push_back(e);
        end
        exp_gen++;
        widx_m++;
        wbuf = '0;
        wcnt = 0;
    endtask

    task automatic emit(input bit fixed, input int p);
        int v;
        logic [11:0] lv;
        wbuf = '0;
        wcnt = 0;
        widx_m = 0;
        for (int i = 0; i < sched.size(); i++) begin
            cbd_coef = '0;
            cbd_num  = 3'(sched[i]);
            for (int l = 0; l < sched[i]; l++) begin
                v = fixed ? -3 : (int'($urandom_range(0, 6)) - 3);
                cbd_coef[3*l +: 3] = 3'(v);
                lv = (v < 0) ? 12'(v + 3329) : 12'(v);
                wbuf[12*wcnt +: 12] = lv;
                wcnt++;
                if (wcnt == 8) push_exp(p);
            end
            cbd_done = (i == sched.size() - 1);
            @(posedge clk); #1;
        end
        cbd_coef = '0;
        cbd_num  = '0;
        cbd_done = 1'b0;
`ifndef CBD_SCHED_CNTCHK_EN
        if (wcnt != 0) push_exp(p);
`endif
    endtask

    task automatic wait_start(input logic [7:0] exp_n);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!o_cbd_start && t < 200);
        chk("start_seen", o_cbd_start, 1);
        chk("cbd_n", o_cbd_n, exp_n);
    endtask

    task automatic run_batch(input logic [7:0] base, input logic [2:0] np_in, input int np_eff,
                             input int kind, input bit fixed, input int limit);
        exp_q.delete();
        exp_gen = 0;
        exp_limit = limit;
        n_start = 0;
        n_done = 0;
        n_words = 0;
        @(posedge clk); #1;
        i_req = 1'b1;
        nonce = base;
        npoly = np_in;
        @(posedge clk); #1;
        i_req = 1'b0;
        chk("busy_on", o_busy, 1);
        chk("err_clr", o_err, 0);
        for (int p = 0; p < np_eff; p++) begin
            wait_start(8'(base + 8'(p)));
            build_sched(kind);
            @(posedge clk); #1;
            if (p > 0) begin
                i_req = 1'b1;
                nonce = 8'h55;
            end
            emit(fixed, p);
            i_req = 1'b0;
            nonce = base;
        end
    endtask

    task automatic wait_done(input int max_cycles);
        int t;
        t = 0;
        while (n_done == 0 && t < max_cycles) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk("done_once", n_done, 1);
        chk("busy_off", o_busy, 0);
        chk("exp_q_empty", exp_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_start", o_cbd_start, 0);
        chk("rst_cbd_n", o_cbd_n, 0);
        chk("rst_data", o_data, 0);
        rst_n = 1'b1;

        i_ready = 1'b1;
        run_batch(8'h04, 3'd2, 2, 0, 1'b0, 1000);
        wait_done(2000);
        chk("t1_words", n_words, 64);
        chk("t1_starts", n_start, 2);
        chk("t1_err", o_err, 0);

        run_batch(8'hA0, 3'd0, 1, 1, 1'b1, 1000);
        wait_done(2000);
        chk("t2_words", n_words, 32);
        chk("t2_starts", n_start, 1);
        chk("t2_err", o_err, 0);

        i_ready = 1'b0;
        run_batch(8'h30, 3'd1, 1, 0, 1'b0, 4);
        repeat (10) @(negedge clk);
        chk("t3_err", o_err, 1);
        chk("t3_valid", o_valid, 1);
        chk("t3_no_done", n_done, 0);
        chk("t3_busy", o_busy, 1);
        @(posedge clk); #1;
        i_ready = 1'b1;
        wait_done(2000);
        chk("t3_words", n_words, 4);
        chk("t3_err_sticky", o_err, 1);

        run_batch(8'h40, 3'd1, 1, 2, 1'b0, 1000);
        wait_done(2000);
`ifdef CBD_SCHED_CNTCHK_EN
        chk("t4_words", n_words, 31);
        chk("t4_err", o_err, 1);
`else
        chk("t4_words", n_words, 32);
        chk("t4_err", o_err, 0);
`endif

        run_batch(8'hFE, 3'd7, 4, 0, 1'b0, 1000);
        wait_done(4000);
        chk("t5_words", n_words, 128);
        chk("t5_starts", n_start, 4);
        chk("t5_err", o_err, 0);

        sb_en = 1'b0;
        i_ready = 1'b0;
        @(posedge clk); #1;
        i_req = 1'b1;
        nonce = 8'h20;
        npoly = 3'd3;
        @(posedge clk); #1;
        i_req = 1'b0;
        wait_start(8'h20);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            cbd_num  = 3'd7;
            cbd_coef = 21'($urandom);
            @(posedge clk); #1;
        end
        cbd_num  = '0;
        cbd_coef = '0;
        chk("t6_ovf_err", o_err, 1);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_busy", o_busy, 0);
        chk("t6_rst_valid", o_valid, 0);
        chk("t6_rst_err", o_err, 0);
        chk("t6_rst_start", o_cbd_start, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_ready = 1'b1;
        sb_en = 1'b1;
        run_batch(8'h10, 3'd1, 1, 0, 1'b0, 1000);
        wait_done(2000);
        chk("t6_words", n_words, 32);
        chk("t6_err", o_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
